// File: rtl/mmio_bridge.sv
// CPU data-port MMIO bridge: decodes addr[31:20] into data memory or internal peripherals
// (tick counters, keyboard FIFO, LED/HEX/VGA line registers, sticky error status).
module mmio_bridge #(
    parameter int unsigned NUM_TIMERS    = 3,
    parameter int unsigned TIMER_PERIOD0 = 50000000,
    parameter int unsigned TIMER_PERIODK = 50000,
    parameter int unsigned KBD_DEPTH     = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_we,
    input  logic [7:0]  key_code,
    input  logic        key_valid,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [31:0] hex,
    output logic [31:0] vga_line,
    output logic        vga_wr_en,
    output logic [11:0] vga_wr_addr,
    output logic [7:0]  vga_wr_data
);
    localparam int unsigned KAW = $clog2(KBD_DEPTH);
    localparam logic [11:0] RegData = 12'h001, RegVgaInfo = 12'h002, RegVgaLine = 12'h003,
                            RegKbd = 12'h004, RegHex = 12'h005, RegTimer = 12'h006,
                            RegSw = 12'h007, RegLed = 12'h008, RegStatus = 12'h00F;

    logic [11:0]    region;
    logic [3:0]     tmr_ch;
    logic           tmr_ok, kbd_empty, kbd_full, kbd_pop, kbd_push, ovf_set, status_clr;
    logic           rd_err, wr_err;
    logic [31:0]    rd_val, tmr_rd;

    logic [31:0]    rdata_q, rdata_d, hex_q, hex_d, vga_line_q, vga_line_d;
    logic           sel_data_q, sel_data_d, ovf_q, ovf_d;
    logic [15:0]    led_q, led_d;
    logic [1:0]     errno_q, errno_d;
    logic [27:0]    err_addr_q, err_addr_d;
    logic [7:0]     kbd_mem_q [KBD_DEPTH], kbd_mem_d [KBD_DEPTH];
    logic [KAW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [KAW:0]   kbd_cnt_q, kbd_cnt_d;
    logic [31:0]    tcnt_q [NUM_TIMERS], tcnt_d [NUM_TIMERS];
    logic [31:0]    tper_q [NUM_TIMERS], tper_d [NUM_TIMERS];
    logic [31:0]    tps_q [NUM_TIMERS], tps_d [NUM_TIMERS];

    assign region     = addr[31:20];
    assign tmr_ch     = addr[6:3];
    assign tmr_ok     = 32'(tmr_ch) < NUM_TIMERS;
    assign kbd_empty  = kbd_cnt_q == '0;
    assign kbd_full   = kbd_cnt_q == (KAW+1)'(KBD_DEPTH);
    assign kbd_pop    = re && (region == RegKbd) && !kbd_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
    assign kbd_push   = key_valid && (!kbd_full || kbd_pop);
    assign ovf_set    = key_valid && kbd_full && !kbd_pop;
    assign status_clr = we && (region == RegStatus);

    assign dmem_we     = we && (region == RegData);
    assign vga_wr_en   = we && (region == RegVgaInfo);
    assign vga_wr_addr = addr[11:0];
    assign vga_wr_data = wdata[7:0];
    assign rdata       = sel_data_q ? dmem_rdata : rdata_q;
    assign led         = led_q;
    assign hex         = hex_q;
    assign vga_line    = vga_line_q;

    always_comb begin
        tmr_rd = '0;
        for (int i = 0; i < int'(NUM_TIMERS); i++) begin
            if (tmr_ch == 4'(i)) tmr_rd = addr[2] ? tper_q[i] : tcnt_q[i];
        end
    end

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        wr_err = 1'b0;
        case (region)
            RegData:    rd_val = '0;
            RegVgaInfo: rd_err = 1'b1;
            RegVgaLine: rd_val = vga_line_q;
            RegKbd: begin
                wr_err = 1'b1;
                rd_val = kbd_empty ? 32'h0 : {23'h0, 1'b1, kbd_mem_q[rd_ptr_q]};
            end
            RegHex:     rd_val = hex_q;
            RegTimer: begin
                rd_err = !tmr_ok;
                wr_err = !tmr_ok;
                rd_val = tmr_ok ? tmr_rd : 32'h0;
            end
            RegSw: begin
                wr_err = 1'b1;
                rd_val = {16'h0, sw};
            end
            RegLed:     rd_val = {16'h0, led_q};
            RegStatus:  rd_val = {err_addr_q, ovf_q, kbd_empty, errno_q};
            default: begin
                rd_err = 1'b1;
                wr_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        rdata_d    = re ? rd_val : rdata_q;
        sel_data_d = re ? (region == RegData) : sel_data_q;
        led_d      = (we && region == RegLed) ? wdata[15:0] : led_q;
        hex_d      = (we && region == RegHex) ? wdata : hex_q;
        vga_line_d = (we && region == RegVgaLine) ? wdata : vga_line_q;

        errno_d    = errno_q;
        err_addr_d = err_addr_q;
        ovf_d      = ovf_q;
        if (status_clr) begin
            errno_d    = '0;
            err_addr_d = '0;
            ovf_d      = 1'b0;
        end else if (errno_q == 2'd0) begin
            if (re && rd_err) begin
                errno_d    = 2'd1;
                err_addr_d = addr[27:0];
            end else if (we && wr_err) begin
                errno_d    = 2'd2;
                err_addr_d = addr[27:0];
            end
        end
        if (ovf_set) ovf_d = 1'b1;

        kbd_mem_d = kbd_mem_q;
        if (kbd_push) kbd_mem_d[wr_ptr_q] = key_code;
        wr_ptr_d  = kbd_push ? wr_ptr_q + KAW'(1) : wr_ptr_q;
        rd_ptr_d  = kbd_pop ? rd_ptr_q + KAW'(1) : rd_ptr_q;
        kbd_cnt_d = kbd_cnt_q + (KAW+1)'(kbd_push) - (KAW+1)'(kbd_pop);
    end

    // A write to a channel replaces that cycle's tick entirely.
    always_comb begin
        for (int i = 0; i < int'(NUM_TIMERS); i++) begin
            tcnt_d[i] = tcnt_q[i];
            tper_d[i] = tper_q[i];
            tps_d[i]  = tps_q[i] + 32'd1;
            if (tps_q[i] >= tper_q[i] - 32'd1) begin
                tps_d[i]  = '0;
                tcnt_d[i] = tcnt_q[i] + 32'd1;
            end
            if (we && region == RegTimer && tmr_ch == 4'(i)) begin
                tps_d[i]  = '0;
                tcnt_d[i] = tcnt_q[i];
                if (addr[2]) tper_d[i] = (wdata == '0) ? 32'd1 : wdata;
                else         tcnt_d[i] = wdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q    <= '0;
            sel_data_q <= 1'b0;
            led_q      <= '0;
            hex_q      <= '0;
            vga_line_q <= '0;
            ovf_q      <= 1'b0;
            errno_q    <= '0;
            err_addr_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            kbd_cnt_q  <= '0;
            for (int i = 0; i < int'(KBD_DEPTH); i++) kbd_mem_q[i] <= '0;
            for (int i = 0; i < int'(NUM_TIMERS); i++) begin
                tcnt_q[i] <= '0;
                tps_q[i]  <= '0;
                tper_q[i] <= (i == 0) ? 32'(TIMER_PERIOD0) : 32'(TIMER_PERIODK);
            end
        end else begin
            rdata_q    <= rdata_d;
            sel_data_q <= sel_data_d;
            led_q      <= led_d;
            hex_q      <= hex_d;
            vga_line_q <= vga_line_d;
            ovf_q      <= ovf_d;
            errno_q    <= errno_d;
            err_addr_q <= err_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            kbd_cnt_q  <= kbd_cnt_d;
            kbd_mem_q  <= kbd_mem_d;
            tcnt_q     <= tcnt_d;
            tper_q     <= tper_d;
            tps_q      <= tps_d;
        end
    end
endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised memory-mapped I/O bridge between the CPU data port and the board peripherals. It decodes `addr[31:20]` into regions and either passes accesses through to data memory or serves them from internal registers. Internal resources: N programmable tick counters, a keyboard scan-code FIFO, LED/HEX/VGA-line registers and a sticky error register. It replaces the ad-hoc read/write muxes at top level.

## Interface
- `NUM_TIMERS`, 3: tick counter channels, 1..8.
- `TIMER_PERIOD0`, 50000000: reset period in clocks for channel 0.
- `TIMER_PERIODK`, 50000: reset period for channels 1..N-1.
- `KBD_DEPTH`, 8: keyboard FIFO entries, power of two, 2..64.

Ports:
- `clock`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  32  CPU data address.
- `wdata`  in  32  CPU write data.
- `we` / `re`  in  1 each  write / read strobe, one cycle per access.
- `rdata`  out  32  read return data.
- `dmem_rdata`  in  32  data-memory read data.
- `dmem_we`  out  1  `we` gated by DATA region (combinational).
- `key_code`  in  8  scan code.
- `key_valid`  in  1  one-cycle push strobe.
- `sw`  in  16  switches.
- `led`  out  16  LED register.
- `hex`  out  32  8×4-bit seven-segment digits.
- `vga_line`  out  32  VGA line register.
- `vga_wr_en`, `vga_wr_addr[11:0]`, `vga_wr_data[7:0]`  out: VGA char-RAM write, combinational from the VGA_INFO region.

## Operation
- Region = `addr[31:20]`:
  - 0x001 DATA
  - 0x002 VGA_INFO (write only)
  - 0x003 VGA_LINE
  - 0x004 KBD
  - 0x005 HEX
  - 0x006 TIMER
  - 0x007 SW (read only)
  - 0x008 LED
  - 0x00F STATUS
- DATA: reads return `dmem_rdata`. Writes assert `dmem_we`.
- VGA_INFO write: `vga_wr_en=1`, `vga_wr_addr=addr[11:0]`, `vga_wr_data=wdata[7:0]`.
- VGA_LINE, HEX, LED: read/write registers. LED keeps `wdata[15:0]`.
- KBD read:
  - Pops the FIFO.
  - Returns `{23'b0, 1'b1, code}` when non-empty, else 0.
- TIMER offset decode: `addr[6:3]` = channel, `addr[2]` = 0 count / 1 period.
  - Channel ≥ `NUM_TIMERS` is an invalid access.
  - Each channel has a prescaler; on reaching `period-1` it wraps to 0 and increments the 32-bit count.
  - The count wraps 0xFFFFFFFF → 0.
  - Period write of 0 stores 1.
  - Count or period write clears that channel's prescaler.
- STATUS read: `{err_addr[27:0] upper bits dropped → addr[27:0], overflow, kbd_empty, errno[1:0]}` packed as `{err_addr[27:0], ovf, empty, errno}`.
  - STATUS write clears `errno`, `err_addr` and `ovf`.
- errno codes: 1 = read of unmapped region or write-only location; 2 = write to unmapped region or read-only location. Invalid-read cases: VGA_INFO, unmapped, bad timer channel. Invalid-write cases: SW, KBD, unmapped, bad timer channel.
  - errno and `err_addr` capture the first error only, until cleared.
  - An invalid read returns 0.
- FIFO push on `key_valid`:
  - If full and no pop this cycle, the code is dropped and `ovf` set (sticky).
  - Simultaneous push+pop when full: both occur, no overflow.
  - Simultaneous push+pop when empty: push occurs, read returns 0.
- `re` and `we` together: write side effects apply; read returns the pre-write value. A KBD pop still occurs.

## Timing
- Read latency 1. `re` sampled at edge N; `rdata` valid from edge N+1 until the next `re`.
- DATA reads: region select registered at N, and `rdata` muxes live `dmem_rdata` during cycle N+1.
- Register writes take effect at the edge sampling `we`.
- Timer write coinciding with a tick: the write wins, and the tick is lost.
- Reset values (asynchronous, while `reset=0`): `rdata`=0; `led`=0; `hex`=0; `vga_line`=0; FIFO empty; `ovf`=0; errno=0; `err_addr`=0.
  - Counts and prescalers are 0; periods are `TIMER_PERIOD0` / `TIMER_PERIODK`.
  - Reset mid-access aborts it, with no side effects after release.

## Test plan
- Reset, then read STATUS (0x00F00000) → `rdata`=0x00000004 (empty=1), one cycle after `re`; `led`=0, `hex`=0.
- Write 0x00000064 to period of ch1 (0x0060000C), then wait 300 clocks → ch1 count (0x00600008) reads 3. Write count=0xFFFFFFFF, wait 100 clocks → reads 0.
- Push 0x1C, 0x32 via `key_valid`, then read KBD twice → 0x11C, 0x132; third read → 0 with empty=1.
- Push `KBD_DEPTH+1` codes without popping → STATUS `ovf`=1. Pops return the first `KBD_DEPTH` codes in order. STATUS write clears `ovf`.
- Write to SW region 0x00700000, then read 0x00900000 → errno stays 2 and `err_addr`=0x00700000 (first error kept). Read returns 0.
- Write 0x41 to 0x00200123 → `vga_wr_en`=1, `vga_wr_addr`=0x123, `vga_wr_data`=0x41, `dmem_we`=0. Write to 0x00100010 → `dmem_we`=1.
